// File: rtl/hkspi_pkg.sv
// Shared constants, state encoding and opcode helpers for the housekeeping SPI responder.
package hkspi_pkg;

    localparam logic [1:0] CMD_WR      = 2'b10;
    localparam logic [1:0] CMD_RD      = 2'b01;
    localparam logic [1:0] CMD_RW      = 2'b11;
    localparam logic [7:0] CMD_PT_MGMT = 8'hC4;
    localparam logic [7:0] CMD_PT_USER = 8'hC6;

    // Bit positions of the host pins in the synchronizer array.
    localparam int PIN_SDI = 0;
    localparam int PIN_CSB = 1;
    localparam int PIN_SCK = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMMAND,
        ST_ADDRESS,
        ST_DATA,
        ST_PASSTHRU,
        ST_IGNORE
    } hk_state_e;

    function automatic logic is_rd(input logic [1:0] mode);
        return (mode == CMD_RD) || (mode == CMD_RW);
    endfunction

    function automatic logic is_wr(input logic [1:0] mode);
        return (mode == CMD_WR) || (mode == CMD_RW);
    endfunction

endpackage

// File: rtl/hkspi_responder_if.sv
// Byte-wide strobe bus between the SPI responder (master) and the housekeeping register file.
interface hkspi_responder_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        reg_rdata;

    modport master (output reg_addr, reg_wdata, reg_wr, reg_rd, input reg_rdata);
    modport slave  (input reg_addr, reg_wdata, reg_wr, reg_rd, output reg_rdata);
endinterface

// File: rtl/hkspi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle rise/fall pulses.
module hkspi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & dly_q;
endmodule

// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder (mode 0): command/address/data decode onto a byte strobe bus,
// plus pass-thru flags that hand the host SPI to the mgmt or user flash.
module hkspi_responder
    import hkspi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sck,
    input  logic              csb,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_enb,
    hkspi_responder_if.master bus,
    output logic              pass_thru_mgmt,
    output logic              pass_thru_user
);
    logic [2:0] lvl, rise, fall;

    hkspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [2:0] (
        .clock  (clock),
        .reset  (reset),
        .pin_i  ({sck, csb, sdi}),
        .lvl_o  (lvl),
        .rise_o (rise),
        .fall_o (fall)
    );

    logic sck_rise, sck_fall, csb_s, csb_fall, sdi_s;
    assign sck_rise = rise[PIN_SCK];
    assign sck_fall = fall[PIN_SCK];
    assign csb_s    = lvl[PIN_CSB];
    assign csb_fall = fall[PIN_CSB];
    assign sdi_s    = lvl[PIN_SDI];

    logic edges_unused;
    assign edges_unused = ^{lvl[PIN_SCK], rise[PIN_CSB], rise[PIN_SDI], fall[PIN_SDI]};

    hk_state_e         state_q;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        rx_q;
    logic [7:0]        tx_q;
    logic [1:0]        mode_q;
    logic [2:0]        rem_q;      // bytes left in fixed-count mode, 0 = stream
    logic [ADDR_W-1:0] reg_addr_q;
    logic [7:0]        reg_wdata_q;
    logic              reg_wr_q, reg_rd_q;
    logic              cap_q, inc_q, rdn_q;
    logic              sdo_q, sdo_enb_q, pt_mgmt_q, pt_user_q;

    logic [7:0] rx_d;
    assign rx_d = {rx_q, sdi_s};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            mode_q      <= '0;
            rem_q       <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            cap_q       <= 1'b0;
            inc_q       <= 1'b0;
            rdn_q       <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_enb_q   <= 1'b1;
            pt_mgmt_q   <= 1'b0;
            pt_user_q   <= 1'b0;
        end else begin
            // Per-byte pipeline: strobe -> address increment + next read -> capture into tx.
            reg_wr_q <= 1'b0;
            reg_rd_q <= rdn_q;
            cap_q    <= reg_rd_q;
            inc_q    <= 1'b0;
            rdn_q    <= 1'b0;
            if (cap_q) tx_q <= bus.reg_rdata;
            if (inc_q) reg_addr_q <= reg_addr_q + ADDR_W'(1);

            if (csb_s) begin
                state_q   <= ST_IDLE;
                reg_rd_q  <= 1'b0;
                cap_q     <= 1'b0;
                sdo_q     <= 1'b0;
                sdo_enb_q <= 1'b1;
                pt_mgmt_q <= 1'b0;
                pt_user_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (csb_fall) begin
                        state_q   <= ST_COMMAND;
                        bit_cnt_q <= '0;
                    end
                    ST_COMMAND: if (sck_rise) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        rx_q      <= rx_d[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_d == CMD_PT_MGMT) begin
                                state_q   <= ST_PASSTHRU;
                                pt_mgmt_q <= 1'b1;
                            end else if (rx_d == CMD_PT_USER) begin
                                state_q   <= ST_PASSTHRU;
                                pt_user_q <= 1'b1;
                            end else if (rx_d[2:0] == 3'b000 && rx_d[7:6] != 2'b00) begin
                                state_q <= ST_ADDRESS;
                                mode_q  <= rx_d[7:6];
                                rem_q   <= rx_d[5:3];
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDRESS: if (sck_rise) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        rx_q      <= rx_d[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            state_q    <= ST_DATA;
                            reg_addr_q <= ADDR_W'(rx_d);
                            if (is_rd(mode_q)) begin
                                reg_rd_q  <= 1'b1;
                                sdo_enb_q <= 1'b0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_fall && is_rd(mode_q)) begin
                            sdo_q <= tx_q[7];
                            tx_q  <= {tx_q[6:0], 1'b0};
                        end
                        if (sck_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            rx_q      <= rx_d[6:0];
                            if (bit_cnt_q == 3'd7) begin
                                if (is_wr(mode_q)) begin
                                    reg_wdata_q <= rx_d;
                                    reg_wr_q    <= 1'b1;
                                end
                                inc_q <= 1'b1;
                                if (rem_q == 3'd1) begin
                                    state_q   <= ST_IGNORE;
                                    sdo_enb_q <= 1'b1;
                                end else begin
                                    if (rem_q != 3'd0) rem_q <= rem_q - 3'd1;
                                    rdn_q <= is_rd(mode_q);
                                end
                            end
                        end
                    end
                    ST_PASSTHRU: ;
                    ST_IGNORE:   sdo_enb_q <= 1'b1;
                    default:     state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign sdo            = sdo_q;
    assign sdo_enb        = sdo_enb_q;
    assign pass_thru_mgmt = pt_mgmt_q;
    assign pass_thru_user = pt_user_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_wdata  = reg_wdata_q;
    assign bus.reg_wr     = reg_wr_q;
    assign bus.reg_rd     = reg_rd_q;
endmodule
